and4gate_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 4-input AND gate (`and4gate`). On a start pulse it drives all 16 input combinations onto the gate, waits a programmable settle time, samples the gate output and compares it against the expected AND result. It reports a pass/fail verdict, a mismatch count and the first failing vector. It sits beside the gate in lab top levels and replaces the hand-written exhaustive stimulus with on-chip checking.

---
 rtl/and4gate_bist_ctrl_if.sv | 29 ++
 rtl/and4gate_bist_ctrl.sv | 107 ++++++++++
 tb/tb_and4gate_bist_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/and4gate_bist_ctrl_if.sv
// Bundle between the AND4 BIST sequencer and its host:
// run control, gate stimulus/response and the result registers.
interface and4gate_bist_ctrl_if;
  logic       start;
  logic       abort;
  logic       f_in;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] first_fail_vec;

  modport master (
    output start, abort, f_in,
    input  a, b, c, d, busy, done, pass,
    input  err_count, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, abort, f_in,
    output a, b, c, d, busy, done, pass,
    output err_count, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/and4gate_bist_ctrl.sv
// Exhaustive self-test sequencer for a 4-input AND gate:
// steps 16 vectors, checks f_in after a settle time, logs errors.
module and4gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  and4gate_bist_ctrl_if.slave         bist
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] r_state;
  logic [3:0] r_vec;
  logic [3:0] r_cnt;
  logic [4:0] r_err;
  logic       r_pass;
  logic       r_fv;
  logic [3:0] r_ffv;

  logic       w_drive;
  logic       w_mis;
  logic [4:0] w_err_nxt;

  assign w_drive   = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign w_mis     = bist.f_in != (&r_vec);
  assign w_err_nxt = r_err + {4'd0, w_mis};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= 4'd0;
      r_cnt   <= 4'd0;
      r_err   <= 5'd0;
      r_pass  <= 1'b0;
      r_fv    <= 1'b0;
      r_ffv   <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bist.start) begin
            r_state <= S_SETTLE;
            r_vec   <= 4'd0;
            r_cnt   <= 4'd0;
            r_err   <= 5'd0;
            r_pass  <= 1'b0;
            r_fv    <= 1'b0;
            r_ffv   <= 4'd0;
          end
        end
        S_SETTLE: begin
          if (bist.abort) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= S_CHECK;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (bist.abort) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
          end else begin
            r_err <= w_err_nxt;
            if (w_mis && !r_fv) begin
              r_fv  <= 1'b1;
              r_ffv <= r_vec;
            end
            // verdict lands with the done pulse, so use the post-check count
            if (r_vec == 4'hF) begin
              r_state <= S_DONE;
              r_pass  <= (w_err_nxt == 5'd0);
            end else begin
              r_state <= S_SETTLE;
              r_vec   <= r_vec + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_vec   <= 4'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bist.a              = w_drive & r_vec[3];
  assign bist.b              = w_drive & r_vec[2];
  assign bist.c              = w_drive & r_vec[1];
  assign bist.d              = w_drive & r_vec[0];
  assign bist.busy           = w_drive;
  assign bist.done           = (r_state == S_DONE);
  assign bist.pass           = r_pass;
  assign bist.err_count      = r_err;
  assign bist.fail_valid     = r_fv;
  assign bist.first_fail_vec = r_ffv;

endmodule

// File: tb/tb_and4gate_bist_ctrl.sv
// Scoreboard bench for the AND4 BIST sequencer: run results
// are queued at start and checked by a monitor on each done pulse.
module tb_and4gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and4gate_bist_ctrl_if bi2 ();
  and4gate_bist_ctrl_if bi1 ();

  and4gate_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bist  (bi2)
  );

  and4gate_bist_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bist  (bi1)
  );

  // gate models: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted
  int         mode = 0;
  logic [3:0] v2;
  logic [3:0] v1;
  assign v2 = {bi2.a, bi2.b, bi2.c, bi2.d};
  assign v1 = {bi1.a, bi1.b, bi1.c, bi1.d};
  assign bi2.f_in = (mode == 0) ? (&v2) :
                    (mode == 1) ? 1'b0 :
                    (mode == 2) ? 1'b1 : ~(&v2);
  assign bi1.f_in = ~(&v1);

  typedef struct {
    int   lat;
    logic pass;
    int   err;
    logic fv;
    int   ffv;
  } exp_t;

  exp_t q[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   e0 = 0;
  int   e0_1 = 0;
  int   seen1 = 0;
  bit   vec_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bi2.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_lat", cyc - e0, e.lat);
        chk("pass", int'(bi2.pass), int'(e.pass));
        chk("err_count", int'(bi2.err_count), e.err);
        chk("fail_valid", int'(bi2.fail_valid), int'(e.fv));
        chk("first_fail_vec", int'(bi2.first_fail_vec), e.ffv);
      end
    end
    if (rst_n && vec_on && bi2.busy)
      chk("vec_seq", int'(v2), (cyc - e0) / 3);
  end

  always @(negedge clk) begin
    if (rst_n && bi1.done) begin
      seen1++;
      chk("s1_done_lat", cyc - e0_1, 32);
      chk("s1_err_count", int'(bi1.err_count), 16);
      chk("s1_first_fail", int'(bi1.first_fail_vec), 0);
      chk("s1_fail_valid", int'(bi1.fail_valid), 1);
      chk("s1_pass", int'(bi1.pass), 0);
    end
  end

  task automatic pulse_start2();
    @(negedge clk);
    bi2.start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    bi2.start = 1'b0;
  endtask

  task automatic drain(int budget);
    repeat (budget) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_full(exp_t e, int budget);
    q.push_back(e);
    pulse_start2();
    drain(budget);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, int'(bi2.busy), 0);
    chk({tag, "_done"}, int'(bi2.done), 0);
    chk({tag, "_pass"}, int'(bi2.pass), 0);
    chk({tag, "_err"}, int'(bi2.err_count), 0);
    chk({tag, "_fv"}, int'(bi2.fail_valid), 0);
    chk({tag, "_ffv"}, int'(bi2.first_fail_vec), 0);
    chk({tag, "_abcd"}, int'(v2), 0);
  endtask

  initial begin
    bi2.start = 1'b0;
    bi2.abort = 1'b0;
    bi1.start = 1'b0;
    bi1.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // good gate, start re-pulsed during vector 5
    mode = 0;
    vec_on = 1'b1;
    q.push_back('{48, 1'b1, 0, 1'b0, 0});
    pulse_start2();
    repeat (15) @(negedge clk);
    bi2.start = 1'b1;
    @(negedge clk);
    bi2.start = 1'b0;
    drain(40);
    vec_on = 1'b0;
    chk("idle_hold_pass", int'(bi2.pass), 1);
    chk("idle_abcd", int'(v2), 0);

    mode = 1;
    run_full('{48, 1'b0, 1, 1'b1, 15}, 55);
    mode = 2;
    run_full('{48, 1'b0, 15, 1'b1, 0}, 55);

    // abort in the CHECK cycle of vector 7; its check is dropped
    mode = 2;
    pulse_start2();
    repeat (23) @(negedge clk);
    bi2.abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(bi2.busy), 0);
    chk("abort_abcd", int'(v2), 0);
    chk("abort_err", int'(bi2.err_count), 7);
    chk("abort_fv", int'(bi2.fail_valid), 1);
    chk("abort_ffv", int'(bi2.first_fail_vec), 0);
    chk("abort_pass", int'(bi2.pass), 0);
    @(negedge clk);
    bi2.abort = 1'b0;
    repeat (30) @(negedge clk);

    // reset during vector 9
    pulse_start2();
    repeat (27) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    run_full('{48, 1'b1, 0, 1'b0, 0}, 55);

    // inverted gate on the S=1 instance
    @(negedge clk);
    bi1.start = 1'b1;
    @(posedge clk);
    #1 e0_1 = cyc;
    @(negedge clk);
    bi1.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("s1_done_seen", seen1, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
